outport_uart_tx: RTL and testbench
==================================

Name: outport_uart_tx

Overview:
- Downstream consumer of the CPU's output port.
- Accepts 32-bit words written to the outport, buffers them in a small word FIFO and serializes each word as four 8N1 UART bytes, least-significant byte first, on a single `tx` pin.
- Sits between the Datapath's `outport_data` and the board serial pin.
- Gives the CPU program visible console output without stalling the processor.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range is 2 and above.
- FIFO_DEPTH, 4, number of 32-bit word entries buffered. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces every register to its reset value immediately.
- word_in  input  32  word to transmit; connects to `outport_data`.
- word_valid  input  1  one-cycle strobe: word_in holds a new outport value this cycle. Driven by the control unit's outport enable delayed one cycle.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a word is being shifted or the FIFO is non-empty.
- fifo_full  output  1  FIFO holds FIFO_DEPTH words.
- fifo_count  output  clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.
- overflow  output  1  sticky: a word_valid arrived while the FIFO was full and was not popped that cycle.

Behaviour:
- Reset values (reset low):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM=IDLE, baud counter=0, bit index=0, byte index=0, read/write pointers=0.
- Reset mid-frame: tx returns to 1 asynchronously, the frame is abandoned, and all FIFO contents are discarded.
- FIFO push: on a rising edge with word_valid=1, word_in is written if (count<FIFO_DEPTH) or a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set to 1. overflow clears only on reset.
- FIFO pop occurs only in IDLE with count>0:
  - the head word loads into a 32-bit shift register;
  - byte index=0; FSM→START.
- Simultaneous push and pop: count is unchanged and both succeed, including when the FIFO is full.
- FSM states and transitions:
  - IDLE: tx=1. With count>0, pop and go to START; otherwise stay.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx = bit[bit index] of the current byte, each bit held CLKS_PER_BIT cycles, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte index<3, increment the byte index, select the next byte (word bits [8k+7:8k]) and go to START with no idle gap;
    - else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each state or bit advance. It is reset to 0 on every state entry.
- Byte order: word 0xAABBCCDD is sent as 0xDD, 0xCC, 0xBB, 0xAA.
- Latency: word_valid at edge E with an empty FIFO and FSM in IDLE:
  - the FIFO write occurs at E;
  - the pop occurs at E+1;
  - tx falls to 0 immediately after E+1.
- Word duration: exactly 40×CLKS_PER_BIT cycles from start-bit fall to the end of the last stop bit, plus 1 IDLE cycle before the next pop.
- busy = (FSM≠IDLE) or (count>0). It is registered in step with the FSM, so it is never low while a frame is in flight.
- tx is driven from a register, so there are no combinational glitches on the pin.
- fifo_full = (count==FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- word_valid held high for several cycles is treated as one push per cycle. No edge detection is performed.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Release reset and idle 20 cycles → tx=1, busy=0, fifo_count=0, overflow=0 throughout.
- Single word 0x12345678 with word_valid pulse at cycle 10:
  - tx falls after cycle 11;
  - bytes decoded are 0x78, 0x56, 0x34, 0x12, each as 0,b0..b7,1 with every bit exactly 4 cycles wide;
  - busy is high for 161 cycles then low;
  - tx is back at 1.
- Burst of 6 consecutive word_valid cycles with values 1..6:
  - word 1 pops and begins shifting; words 2–5 fill the FIFO; fifo_full=1; word 6 is dropped and overflow=1;
  - the serial output is exactly words 1..5 in order and overflow stays 1 afterwards.
- FIFO full (4 queued) with word_valid coinciding with the IDLE pop cycle → the push is accepted, count stays 4, and overflow stays 0.
- Assert reset low during DATA bit 3 of byte 1 of 0xDEADBEEF:
  - tx=1 in the same cycle (asynchronously) and fifo_count=0;
  - after release no further bits are transmitted;
  - a new word 0x000000A5 then transmits cleanly.
- CLKS_PER_BIT=2, back-to-back words 0xFFFFFFFF and 0x00000000 queued → the bit periods are 2 cycles, exactly one IDLE cycle (tx=1) separates the two words, and there is no gap between bytes within a word.

Source files
------------

// File: rtl/outport_uart_tx.sv
// -----------------------------------------------------------------------------
// outport_uart_tx
//
// Console output path for the CPU's output port. Each 32-bit word written to
// the outport is queued in a small word FIFO. The words are then sent on a
// single UART pin as four 8N1 bytes, least-significant byte first. The CPU is
// never stalled. A word that arrives while the FIFO is full is dropped, and the
// sticky overflow flag records the drop.
//
// Ports
//   clk         system clock, rising-edge
//   reset       asynchronous active-low reset
//   word_in     word to transmit (outport_data)
//   word_valid  one-cycle strobe: word_in is a new outport value; one push
//               per high cycle
//   tx          UART serial line, registered, idles high
//   busy        frame in flight or FIFO non-empty
//   fifo_full   FIFO holds FIFO_DEPTH words
//   fifo_count  words currently queued
//   overflow    sticky: a word was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module outport_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [31:0]                 word_in,
   input  logic                        word_valid,
   output logic                        tx,
   output logic                        busy,
   output logic                        fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [1:0]    byte_idx, byte_n;
   logic [31:0]   word_q, word_n;
   logic [7:0]    cur_byte;
   logic          tx_n;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          pop, push;

   // ---------------------------------------------------------------- FIFO
   // A full FIFO still accepts a word in the cycle it pops. The slot being
   // read is freed in that same edge, so the count does not change.
   assign fifo_full  = (count == COUNT_FULL);
   assign fifo_count = count;
   assign push       = word_valid && (!fifo_full || pop);

   // The storage is not reset. The pointers and count decide which entries
   // are valid, so a reset discards the queued words.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= word_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (word_valid && !push)
            overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------- serializer FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         word_q   <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         word_q   <= word_n;
         tx       <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      word_n  = word_q;
      pop     = 1'b0;

      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               word_n  = mem[rd_ptr];
               byte_n  = '0;
               bit_n   = '0;
               baud_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud == BAUD_LAST) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = DATA;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               if (bit_idx == 3'd7)
                  state_n = STOP;
               else
                  bit_n = bit_idx + 1'b1;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud == BAUD_LAST) begin
               baud_n = '0;
               // Bytes within one word follow each other with no idle gap.
               if (byte_idx != 2'd3) begin
                  byte_n  = byte_idx + 1'b1;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // The pin level is computed from the next-state values and then
      // registered. This makes tx change on the same edge as the FSM, so the
      // start bit begins right after the pop edge and the pin cannot glitch.
      cur_byte = word_n[{byte_n, 3'b000} +: 8];
      unique case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = cur_byte[bit_n];
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
   end

   // busy is derived only from registers that change on the same edge as the
   // FSM, so it never drops while a frame is still in flight.
   assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_outport_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_outport_uart_tx
//
// Directed bench for outport_uart_tx with two instances: CLKS_PER_BIT=4 and
// CLKS_PER_BIT=2, both with FIFO_DEPTH=4. When a word is driven, its bytes
// are queued as the expected stream. A UART receiver decodes each tx line and
// compares every byte against that queue. The receiver also logs the cycle of
// each start bit, which is used for the latency and gap checks.
// -----------------------------------------------------------------------------
module tb_outport_uart_tx;

   logic        clk;
   logic        rst_n;
   logic [31:0] wd4, wd2;
   logic        wv4, wv2;
   logic        tx4, busy4, full4, ovf4;
   logic        tx2, busy2, full2, ovf2;
   logic [2:0]  cnt4, cnt2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] exp4[$];
   logic [7:0] exp2[$];
   int         starts4[$];
   int         starts2[$];

   outport_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
      .clk(clk), .reset(rst_n), .word_in(wd4), .word_valid(wv4),
      .tx(tx4), .busy(busy4), .fifo_full(full4), .fifo_count(cnt4),
      .overflow(ovf4)
   );

   outport_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .reset(rst_n), .word_in(wd2), .word_valid(wv2),
      .tx(tx2), .busy(busy2), .fifo_full(full2), .fifo_count(cnt2),
      .overflow(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the n-th following rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Queue the four bytes of a word, LSB first, as the expected serial stream.
   task automatic push_exp(input int sel, input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         if (sel == 0) exp4.push_back(w[8*k +: 8]);
         else          exp2.push_back(w[8*k +: 8]);
      end
   endtask

   function automatic logic tx_of(input int sel);
      return (sel == 0) ? tx4 : tx2;
   endfunction

   // UART receiver. It samples on falling edges. A low line is taken as the
   // first cycle of a start bit. Every bit must hold one level for its full
   // CLKS_PER_BIT samples. A frame that sees reset is abandoned.
   task automatic uart_mon(input int sel);
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_of(sel) === 1'b0) begin
            int         cpb;
            logic [7:0] b;
            logic       v;
            bit         ok;
            bit         abort;
            cpb   = (sel == 0) ? 4 : 2;
            ok    = 1'b1;
            abort = 1'b0;
            b     = '0;
            v     = 1'b0;
            if (sel == 0) starts4.push_back(cyc);
            else          starts2.push_back(cyc);
            for (int bn = 0; bn < 10 && !abort; bn++) begin
               for (int c = 0; c < cpb; c++) begin
                  if (!(bn == 0 && c == 0)) @(negedge clk);
                  if (rst_n !== 1'b1) abort = 1'b1;
                  if (c == 0) v = tx_of(sel);
                  else if (tx_of(sel) !== v) ok = 1'b0;
               end
               if (bn == 0 && v !== 1'b0) ok = 1'b0;
               if (bn == 9 && v !== 1'b1) ok = 1'b0;
               if (bn >= 1 && bn <= 8) b[bn-1] = v;
            end
            if (!abort) begin
               chk((sel == 0) ? "frame4" : "frame2", ok, 1);
               if (sel == 0) begin
                  chk("sb4_nonempty", exp4.size() > 0, 1);
                  if (exp4.size() > 0) chk("byte4", b, exp4.pop_front());
               end else begin
                  chk("sb2_nonempty", exp2.size() > 0, 1);
                  if (exp2.size() > 0) chk("byte2", b, exp2.pop_front());
               end
            end
         end
      end
   endtask

   initial uart_mon(0);
   initial uart_mon(1);

   // Wait, with a cycle bound, until the instance is idle and its expected
   // queue has been fully consumed.
   task automatic drain(input int sel, input int bound);
      bit done;
      done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         if (sel == 0) done = (busy4 === 1'b0) && (exp4.size() == 0);
         else          done = (busy2 === 1'b0) && (exp2.size() == 0);
      end
      chk((sel == 0) ? "drain4" : "drain2", done, 1);
      step(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int  e, nst, n;
      bit  quiet;
      rst_n = 1'b0; wv4 = 1'b0; wd4 = '0; wv2 = 1'b0; wd2 = '0;
      step(3);

      // Reset values
      chk("rst_tx",    tx4,   1);
      chk("rst_busy",  busy4, 0);
      chk("rst_full",  full4, 0);
      chk("rst_count", cnt4,  0);
      chk("rst_ovf",   ovf4,  0);
      chk("rst_tx2",   tx2,   1);
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("idle", {tx4, busy4, full4, ovf4, cnt4}, 7'b1000000);
      end

      // Single word: latency, busy length, byte spacing
      nst = starts4.size();
      wd4 = 32'h12345678; wv4 = 1'b1; push_exp(0, 32'h12345678);
      step(1); e = cyc; wv4 = 1'b0;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (busy4 === 1'b1) n++;
         else break;
      end
      chk("busy_len", n, 161);
      chk("start_cnt", starts4.size() - nst, 4);
      if (starts4.size() - nst == 4) begin
         chk("first_start", starts4[nst], e + 1);
         for (int k = 1; k < 4; k++)
            chk("byte_gap", starts4[nst+k] - starts4[nst+k-1], 40);
      end
      drain(0, 200);
      chk("tx_idle_after", tx4, 1);

      // Burst of 6: words 1..5 queued, word 6 dropped
      for (int k = 1; k <= 6; k++) begin
         wd4 = k; wv4 = 1'b1;
         if (k <= 5) push_exp(0, k);
         step(1);
      end
      wv4 = 1'b0;
      chk("burst_full",  full4, 1);
      chk("burst_count", cnt4,  4);
      chk("burst_ovf",   ovf4,  1);
      drain(0, 2000);
      chk("burst_ovf_sticky", ovf4, 1);
      chk("burst_count_end",  cnt4, 0);

      rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
      chk("ovf_cleared", ovf4, 0);

      // Full FIFO, with a push on the same cycle as the IDLE pop
      wd4 = 32'hA0A0A0A0; wv4 = 1'b1; push_exp(0, 32'hA0A0A0A0);
      step(1); e = cyc;
      for (int k = 1; k <= 4; k++) begin
         wd4 = 32'hB0B0B000 + k; push_exp(0, 32'hB0B0B000 + k);
         step(1);
      end
      wv4 = 1'b0;
      while (cyc < e + 161) step(1);
      chk("pre_pop_count", cnt4,  4);
      chk("pre_pop_full",  full4, 1);
      wd4 = 32'hC0C0C0C0; wv4 = 1'b1; push_exp(0, 32'hC0C0C0C0);
      step(1); wv4 = 1'b0;
      chk("pop_push_count", cnt4, 4);
      chk("pop_push_ovf",   ovf4, 0);
      drain(0, 1500);
      chk("pop_push_ovf_end", ovf4, 0);

      // Reset during DATA bit 3 of byte 1
      wd4 = 32'hDEADBEEF; wv4 = 1'b1; exp4.push_back(8'hEF);
      step(1); e = cyc;
      wd4 = 32'h11111111;
      step(1); wv4 = 1'b0;
      while (cyc < e + 58) step(1);
      chk("mid_count", cnt4, 1);
      chk("mid_tx_bit3", tx4, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_tx",    tx4,   1);
      chk("async_count", cnt4,  0);
      chk("async_busy",  busy4, 0);
      step(2); rst_n = 1'b1;
      nst = starts4.size();
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (tx4 !== 1'b1 || busy4 !== 1'b0) quiet = 1'b0;
      end
      chk("post_rst_quiet",  quiet, 1);
      chk("post_rst_starts", starts4.size() - nst, 0);
      chk("post_rst_sb",     exp4.size(), 0);
      wd4 = 32'h000000A5; wv4 = 1'b1; push_exp(0, 32'h000000A5);
      step(1); wv4 = 1'b0;
      drain(0, 300);

      // CLKS_PER_BIT=2 back-to-back words
      nst = starts2.size();
      wd2 = 32'hFFFFFFFF; wv2 = 1'b1; push_exp(1, 32'hFFFFFFFF);
      step(1); e = cyc;
      wd2 = 32'h00000000; push_exp(1, 32'h00000000);
      step(1); wv2 = 1'b0;
      drain(1, 400);
      chk("cpb2_starts", starts2.size() - nst, 8);
      if (starts2.size() - nst == 8) begin
         chk("cpb2_first", starts2[nst], e + 1);
         for (int k = 1; k < 8; k++)
            chk("cpb2_gap", starts2[nst+k] - starts2[nst+k-1], (k == 4) ? 21 : 20);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
